lsu_arbiter: RTL and testbench

Two-requester arbiter that shares the single LSU port (data RAM plus memory-mapped LED/HEX/LCD registers) between the core load/store stage (requester 0) and a debug/DMA master (requester 1). It does round-robin arbitration with an optional bounded lock, drives registered address, data and write-enable to the LSU, and decodes I/O writes. It tracks the LSU's registered-read latency and routes returned load data to the requester that issued the read.

---
 rtl/lsu_arbiter.sv | 99 +++++++++
 tb/tb_lsu_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/lsu_arbiter.sv
// lsu_arbiter: round-robin two-requester LSU port arbiter with bounded lock and read-return routing
module lsu_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MAX_HOLD = 4,
  parameter logic [ADDR_W-1:0] IO_BASE = 32'h00001C00,
  parameter logic [ADDR_W-1:0] IO_LAST = 32'h00001C0F
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req0,
  input  logic              i_wren0,
  input  logic              i_lock0,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [DATA_W-1:0] i_wdata0,
  output logic              o_gnt0,
  output logic              o_rvalid0,
  output logic [DATA_W-1:0] o_rdata0,
  input  logic              i_req1,
  input  logic              i_wren1,
  input  logic              i_lock1,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [DATA_W-1:0] i_wdata1,
  output logic              o_gnt1,
  output logic              o_rvalid1,
  output logic [DATA_W-1:0] o_rdata1,
  output logic [ADDR_W-1:0] o_lsu_addr,
  output logic [DATA_W-1:0] o_st_data,
  output logic              o_lsu_wren,
  output logic              o_io_wren,
  input  logic [DATA_W-1:0] i_ld_data,
  output logic              o_busy
);
  localparam logic [3:0] MAX_H = 4'(MAX_HOLD);
  logic last_owner, locked, both, force_sw, sel1, accept, owner_req;
  logic a_wren, a_lock, io_hit;
  logic [3:0] hold_cnt;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata, rd0_q, rd1_q;
  logic tag1_v, tag1_o, tag2_v, tag2_o;
  // grant selection and accepted-request mux; a forced switch fires once the lock holder hits the bound
  always_comb begin
    both = i_req0 & i_req1;
    force_sw = both & locked & (hold_cnt >= MAX_H);
    sel1 = both ? ((locked & ~force_sw) ? last_owner : ~last_owner) : i_req1;
    o_gnt1 = ~i_rst & i_req1 & sel1;
    o_gnt0 = ~i_rst & i_req0 & ~sel1;
    accept = o_gnt0 | o_gnt1;
    owner_req = last_owner ? i_req1 : i_req0;
    a_addr = o_gnt1 ? i_addr1 : i_addr0;
    a_wdata = o_gnt1 ? i_wdata1 : i_wdata0;
    a_wren = o_gnt1 ? i_wren1 : i_wren0;
    a_lock = o_gnt1 ? i_lock1 : i_lock0;
    io_hit = (a_addr >= IO_BASE) && (a_addr <= IO_LAST);
  end
  // issue registers, read-tag shift, held load data and lock/ownership state
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_lsu_addr <= '0;
      o_st_data <= '0;
      o_lsu_wren <= 1'b0;
      o_io_wren <= 1'b0;
      tag1_v <= 1'b0;
      tag1_o <= 1'b0;
      tag2_v <= 1'b0;
      tag2_o <= 1'b0;
      rd0_q <= '0;
      rd1_q <= '0;
      last_owner <= 1'b1;
      locked <= 1'b0;
      hold_cnt <= '0;
    end else begin
      o_lsu_wren <= accept & a_wren;
      o_io_wren <= accept & a_wren & io_hit;
      if (accept) begin
        o_lsu_addr <= a_addr;
        o_st_data <= a_wdata;
      end
      tag1_v <= accept & ~a_wren;
      tag1_o <= o_gnt1;
      tag2_v <= tag1_v;
      tag2_o <= tag1_o;
      if (tag2_v & ~tag2_o) rd0_q <= i_ld_data;
      if (tag2_v & tag2_o) rd1_q <= i_ld_data;
      if (accept) begin
        last_owner <= o_gnt1;
        locked <= force_sw ? 1'b0 : a_lock;
        hold_cnt <= (!force_sw && o_gnt1 == last_owner && locked) ? ((hold_cnt == 4'hF) ? 4'hF : hold_cnt + 4'd1) : 4'd1;
      end else if (!owner_req) begin
        locked <= 1'b0;
      end
    end
  end
  assign o_rvalid0 = tag2_v & ~tag2_o;
  assign o_rvalid1 = tag2_v & tag2_o;
  assign o_rdata0 = o_rvalid0 ? i_ld_data : rd0_q;
  assign o_rdata1 = o_rvalid1 ? i_ld_data : rd1_q;
  assign o_busy = tag1_v | tag2_v | o_lsu_wren;
endmodule

// File: tb/tb_lsu_arbiter.sv
// tb_lsu_arbiter: scoreboard bench for lsu_arbiter grants, issue, I/O decode and read return
module tb_lsu_arbiter;
  logic i_clk = 1'b0, i_rst = 1'b1;
  logic i_req0 = 0, i_wren0 = 0, i_lock0 = 0, i_req1 = 0, i_wren1 = 0, i_lock1 = 0;
  logic [31:0] i_addr0 = 0, i_wdata0 = 0, i_addr1 = 0, i_wdata1 = 0, i_ld_data = 0;
  logic o_gnt0, o_gnt1, o_rvalid0, o_rvalid1, o_lsu_wren, o_io_wren, o_busy;
  logic [31:0] o_rdata0, o_rdata1, o_lsu_addr, o_st_data;
  int checks = 0, failures = 0, cyc = 0;
  bit mon_on = 0;
  int q_own[$], q_due[$];
  logic [31:0] last0 = 0, last1 = 0;

  lsu_arbiter dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req0(i_req0), .i_wren0(i_wren0), .i_lock0(i_lock0), .i_addr0(i_addr0), .i_wdata0(i_wdata0),
    .o_gnt0(o_gnt0), .o_rvalid0(o_rvalid0), .o_rdata0(o_rdata0),
    .i_req1(i_req1), .i_wren1(i_wren1), .i_lock1(i_lock1), .i_addr1(i_addr1), .i_wdata1(i_wdata1),
    .o_gnt1(o_gnt1), .o_rvalid1(o_rvalid1), .o_rdata1(o_rdata1),
    .o_lsu_addr(o_lsu_addr), .o_st_data(o_st_data), .o_lsu_wren(o_lsu_wren), .o_io_wren(o_io_wren),
    .i_ld_data(i_ld_data), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge i_clk);
    #1;
    i_ld_data = $urandom;
  endtask

  task automatic idle;
    i_req0 = 0; i_req1 = 0; i_wren0 = 0; i_wren1 = 0; i_lock0 = 0; i_lock1 = 0;
  endtask

  task automatic do_reset;
    idle();
    i_rst = 1;
    tick();
    tick();
    i_rst = 0;
  endtask

  // scoreboard: reads are pushed on accept and must return exactly two cycles later
  always @(negedge i_clk) begin
    if (mon_on) begin
      int o;
      o = -1;
      if (q_due.size() > 0 && q_due[0] == cyc) begin
        o = q_own.pop_front();
        void'(q_due.pop_front());
      end
      chk("rvalid0", o_rvalid0, o == 0);
      chk("rvalid1", o_rvalid1, o == 1);
      if (o == 0) begin chk("rdata0", o_rdata0, i_ld_data); last0 = i_ld_data; end
      else chk("rdata0_hold", o_rdata0, last0);
      if (o == 1) begin chk("rdata1", o_rdata1, i_ld_data); last1 = i_ld_data; end
      else chk("rdata1_hold", o_rdata1, last1);
      if (i_rst) begin
        q_own.delete(); q_due.delete(); last0 = 0; last1 = 0;
      end else begin
        if (i_req0 && o_gnt0 && !i_wren0) begin q_own.push_back(0); q_due.push_back(cyc + 2); end
        if (i_req1 && o_gnt1 && !i_wren1) begin q_own.push_back(1); q_due.push_back(cyc + 2); end
      end
    end
  end

  initial begin
    logic [31:0] io_a[5];
    logic io_e[5];
    logic tie_e[4];
    logic lock_e[6];
    io_a = '{32'h1C08, 32'h1C10, 32'h1BFF, 32'h1C00, 32'h1C0F};
    io_e = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    tie_e = '{1'b0, 1'b1, 1'b0, 1'b1};
    lock_e = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    i_rst = 1; i_req0 = 1;
    tick();
    chk("rst_gnt0", o_gnt0, 0);
    do_reset();
    mon_on = 1;
    chk("rst_addr", o_lsu_addr, 0);
    chk("rst_wren", o_lsu_wren, 0);
    chk("rst_io", o_io_wren, 0);
    chk("rst_busy", o_busy, 0);
    i_req0 = 1; i_addr0 = 32'h10;
    #1;
    chk("rd_gnt0", o_gnt0, 1);
    chk("rd_gnt1", o_gnt1, 0);
    tick();
    idle();
    chk("rd_addr", o_lsu_addr, 32'h10);
    chk("rd_wren", o_lsu_wren, 0);
    chk("rd_busy", o_busy, 1);
    tick(); tick(); tick();
    chk("idle_busy", o_busy, 0);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      i_req0 = 1; i_req1 = 1; i_addr0 = 32'h20 + i; i_addr1 = 32'h40 + i;
      #1;
      chk("tie_gnt1", o_gnt1, tie_e[i]);
      chk("tie_gnt0", o_gnt0, !tie_e[i]);
      tick();
    end
    idle();
    tick(); tick();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      i_req0 = 1; i_req1 = 1; i_lock0 = 1;
      #1;
      chk("lock_gnt1", o_gnt1, lock_e[i]);
      chk("lock_gnt0", o_gnt0, !lock_e[i]);
      tick();
    end
    idle();
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      i_req1 = 1; i_wren1 = 1; i_addr1 = io_a[i]; i_wdata1 = 32'h12345678 + i;
      #1;
      chk("io_gnt1", o_gnt1, 1);
      tick();
      chk("io_wren", o_lsu_wren, 1);
      chk("io_io", o_io_wren, io_e[i]);
      chk("io_data", o_st_data, 32'h12345678 + i);
      chk("io_addr", o_lsu_addr, io_a[i]);
    end
    idle();
    tick();
    chk("wr_end_wren", o_lsu_wren, 0);
    chk("wr_end_io", o_io_wren, 0);
    chk("wr_hold_addr", o_lsu_addr, 32'h1C0F);
    tick();
    i_req0 = 1; i_addr0 = 32'h4;
    #1;
    chk("il_gnt0", o_gnt0, 1);
    tick();
    idle();
    i_req1 = 1; i_addr1 = 32'h8;
    #1;
    chk("il_gnt1", o_gnt1, 1);
    tick();
    idle();
    chk("il_addr", o_lsu_addr, 32'h8);
    tick(); tick(); tick();
    do_reset();
    i_req0 = 1; i_addr0 = 32'h30;
    tick();
    idle();
    i_rst = 1;
    tick();
    chk("mf_rvalid0", o_rvalid0, 0);
    chk("mf_rvalid1", o_rvalid1, 0);
    chk("mf_addr", o_lsu_addr, 0);
    chk("mf_data", o_st_data, 0);
    chk("mf_wren", o_lsu_wren, 0);
    chk("mf_io", o_io_wren, 0);
    chk("mf_busy", o_busy, 0);
    chk("mf_rdata0", o_rdata0, 0);
    chk("mf_rdata1", o_rdata1, 0);
    i_rst = 0;
    i_req0 = 1; i_req1 = 1;
    #1;
    chk("mf_tie_gnt0", o_gnt0, 1);
    tick();
    idle();
    tick(); tick(); tick();
    chk("sb_empty", q_due.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
